cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
- Shares the single external memory port between the I-cache refill path and the D-cache refill/write-back path of the dual-issue core.
- Sequences one fixed-length burst at a time and routes beats back to the owning requester.
- Fixed D-over-I priority, with an anti-starvation counter that protects instruction fetch.
- Honours a hold input driven from the pipeline control (Csr_Memflush / WFI) that blocks new grants.

Parameters:
ADDR_WIDTH, 32, address width (matches `ADDR_WIDTH)
DATA_WIDTH, 32, beat data width
BURST_LEN, 4, beats per transfer (power of two, >=2)
STARVE_LIM, 3, consecutive D grants with I pending before I is forced to win

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
hold  in  1  block new grants; an in-flight burst completes
i_req  in  1  I-side read burst request, level
i_addr  in  ADDR_WIDTH  I-side burst base address
i_gnt  out  1  one-cycle pulse: I request accepted
i_rvalid  out  1  I read beat valid
i_rlast  out  1  final I beat
d_req  in  1  D-side burst request, level
d_we  in  1  1 = write-back, 0 = refill read
d_addr  in  ADDR_WIDTH  D-side burst base address
d_wdata  in  DATA_WIDTH  current write beat data
d_gnt  out  1  one-cycle pulse: D request accepted
d_wnext  out  1  write beat consumed; D presents next beat
d_rvalid  out  1  D read beat valid
d_last  out  1  final D beat (read or write)
rdata  out  DATA_WIDTH  read data, shared by both sides (qualified by *_rvalid)
mem_req  out  1  beat request to memory
mem_we  out  1  beat is a write
mem_addr  out  ADDR_WIDTH  beat address
mem_wdata  out  DATA_WIDTH  write beat data
mem_ack  in  1  beat done (write accepted / read data valid)
mem_rdata  in  DATA_WIDTH  read data
busy  out  1  burst in flight

Behaviour:
- States: IDLE, I_XFER, D_XFER.
- Reset values: state=IDLE, beat=0, starve_cnt=0, base/we registers=0; all outputs 0.
- Arbitration:
  - Evaluated only in IDLE with hold=0.
  - d_req & !(i_req & starve_cnt==STARVE_LIM) -> D_XFER; else i_req -> I_XFER.
  - On the same clock edge: d_gnt or i_gnt pulses for exactly one cycle (registered), base address and d_we are captured, beat=0.
- hold=1 in IDLE: no grant, state stays IDLE; requests stay pending.
- Requester rules:
  - Hold req/addr stable until its gnt.
  - Deassert req in the cycle after gnt unless a new burst is wanted.
  - Dropping req before gnt is legal and produces no grant.
- Starvation counter:
  - D grant while i_req=1: starve_cnt += 1, saturating at STARVE_LIM.
  - Any I grant: starve_cnt=0.
  - D grant with i_req=0: starve_cnt unchanged.
- XFER states:
  - mem_req=1 for the whole burst; mem_we = captured we (0 in I_XFER).
  - mem_addr = base + beat*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH.
  - mem_wdata = d_wdata, combinational.
- Beat completion (mem_ack=1):
  - beat increments.
  - Read: owner's rvalid=1 and rdata=mem_rdata, combinational, same cycle.
  - Write: d_wnext=1, same cycle.
  - Final beat (beat==BURST_LEN-1): *_rlast/d_last=1 with that beat; next state IDLE.
- Back-to-back bursts always have at least one IDLE cycle between them.
- busy=1 in I_XFER/D_XFER, including while hold=1.
- mem_ack in IDLE is ignored; no outputs change.
- Async reset mid-burst: burst abandoned immediately, all state and outputs at reset values. Memory side must tolerate the truncated burst.
- Simultaneous first-cycle i_req and d_req with starve_cnt=0: D wins.

Test Plan:
- Reset, i_req=1, i_addr=0x1000, mem_ack every cycle -> i_gnt pulse cycle 1; mem_addr 0x1000, 0x1004, 0x1008, 0x100C; 4 i_rvalid; i_rlast on 4th beat; IDLE afterwards.
- d_req=1, d_we=1, d_addr=0x2000, d_wdata increments on d_wnext, mem_ack every 2nd cycle -> mem_we=1; each d_wdata value appears on mem_wdata once; d_last on beat 4; 8 cycles in D_XFER.
- i_req and d_req held high continuously, STARVE_LIM=3 -> grant order D,D,D,I,D,D,D,I; starve_cnt returns to 0 after each I grant.
- hold=1 asserted mid D burst with i_req pending -> D burst completes all 4 beats; no i_gnt until the cycle after hold falls.
- rst asserted after beat 2 of an I burst -> mem_req=0 and state=IDLE immediately; a following i_req restarts from beat 0 at i_addr.
- i_addr=0xFFFFFFF8 -> beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.

Source files
------------

// File: rtl/cache_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cache_bus_arbiter
//   Shares one external memory port between the I-cache refill path and the
//   D-cache refill/write-back path. One fixed-length burst is in flight at a
//   time and beats are routed back to the owning requester. D has priority
//   over I, except that I is forced to win after STARVE_LIM consecutive D
//   grants taken while I was waiting. 'hold' blocks new grants but never
//   interrupts a burst that is already running.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   hold                         block new grants (in-flight burst completes)
//   i_req, i_addr                I-side read burst request / base address
//   i_gnt, i_rvalid, i_rlast     I grant pulse, read beat valid, final beat
//   d_req, d_we, d_addr, d_wdata D-side burst request, write flag, base, data
//   d_gnt, d_wnext               D grant pulse, write beat consumed
//   d_rvalid, d_last             D read beat valid, final D beat
//   rdata                        read data shared by both sides
//   mem_req, mem_we, mem_addr,
//   mem_wdata                    beat request towards memory
//   mem_ack, mem_rdata           beat done / read data from memory
//   busy                         burst in flight
// -----------------------------------------------------------------------------
module cache_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned STARVE_LIM = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold,
   // I-cache refill side
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic                  i_rlast,
   // D-cache refill / write-back side
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_wnext,
   output logic                  d_rvalid,
   output logic                  d_last,
   // shared read data
   output logic [DATA_WIDTH-1:0] rdata,
   // memory port
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned CNT_W  = $clog2(STARVE_LIM + 1);
   localparam int unsigned BYTES  = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_XFER = 2'd1,
      D_XFER = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [BEAT_W-1:0]       r_beat;
   logic [CNT_W-1:0]        r_starve;
   logic [ADDR_WIDTH-1:0]   r_base;
   logic                    r_we;
   logic                    r_i_gnt;
   logic                    r_d_gnt;

   logic                    w_starved;
   logic                    w_pick_d;
   logic                    w_pick_i;
   logic                    w_beat_done;
   logic                    w_last_beat;
   logic [ADDR_WIDTH-1:0]   w_offset;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Arbitration, next-state and beat-level outputs
   always_comb begin
      w_state_nxt = r_state;
      w_starved   = 1'b0;
      w_pick_d    = 1'b0;
      w_pick_i    = 1'b0;
      w_beat_done = 1'b0;
      w_last_beat = 1'b0;
      w_offset    = '0;
      i_rvalid    = 1'b0;
      i_rlast     = 1'b0;
      d_rvalid    = 1'b0;
      d_wnext     = 1'b0;
      d_last      = 1'b0;
      rdata       = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      busy        = 1'b0;

      // Beat address is base plus a whole-word offset, wrapping at 2^ADDR_WIDTH
      w_offset = ADDR_WIDTH'(r_beat) * ADDR_WIDTH'(BYTES);

      case (r_state)
         IDLE: begin
            // mem_ack is deliberately ignored here
            if (!hold) begin
               w_starved = i_req && (r_starve == CNT_W'(STARVE_LIM));
               w_pick_d  = d_req && !w_starved;
               w_pick_i  = i_req && !w_pick_d;
            end
            if (w_pick_d) begin
               w_state_nxt = D_XFER;
            end else if (w_pick_i) begin
               w_state_nxt = I_XFER;
            end
         end

         I_XFER: begin
            busy        = 1'b1;
            mem_req     = 1'b1;
            mem_addr    = r_base + w_offset;
            w_beat_done = mem_ack;
            w_last_beat = mem_ack && (r_beat == BEAT_W'(BURST_LEN - 1));
            i_rvalid    = mem_ack;
            i_rlast     = w_last_beat;
            if (mem_ack) begin
               rdata = mem_rdata;
            end
            if (w_last_beat) begin
               w_state_nxt = IDLE;
            end
         end

         D_XFER: begin
            busy        = 1'b1;
            mem_req     = 1'b1;
            mem_we      = r_we;
            mem_addr    = r_base + w_offset;
            w_beat_done = mem_ack;
            w_last_beat = mem_ack && (r_beat == BEAT_W'(BURST_LEN - 1));
            d_last      = w_last_beat;
            if (r_we) begin
               mem_wdata = d_wdata;
               d_wnext   = mem_ack;
            end else begin
               d_rvalid = mem_ack;
               if (mem_ack) begin
                  rdata = mem_rdata;
               end
            end
            if (w_last_beat) begin
               w_state_nxt = IDLE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Burst context, grant pulses and starvation counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat   <= '0;
         r_starve <= '0;
         r_base   <= '0;
         r_we     <= 1'b0;
         r_i_gnt  <= 1'b0;
         r_d_gnt  <= 1'b0;
      end else begin
         r_i_gnt <= w_pick_i;
         r_d_gnt <= w_pick_d;

         if (w_pick_d) begin
            r_base <= d_addr;
            r_we   <= d_we;
            r_beat <= '0;
         end else if (w_pick_i) begin
            r_base <= i_addr;
            r_we   <= 1'b0;
            r_beat <= '0;
         end else if (w_beat_done) begin
            // Wraps back to zero after the last beat (BURST_LEN is a power of two)
            r_beat <= r_beat + BEAT_W'(1);
         end

         // Only D grants taken while I waits count towards starvation
         if (w_pick_i) begin
            r_starve <= '0;
         end else if (w_pick_d && i_req && (r_starve != CNT_W'(STARVE_LIM))) begin
            r_starve <= r_starve + CNT_W'(1);
         end
      end
   end

   assign i_gnt = r_i_gnt;
   assign d_gnt = r_d_gnt;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
module tb_cache_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        hold;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic        i_rlast;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_wnext;
   logic        d_rvalid;
   logic        d_last;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   cache_bus_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .BURST_LEN (4),
      .STARVE_LIM(3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .hold     (hold),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_gnt    (i_gnt),
      .i_rvalid (i_rvalid),
      .i_rlast  (i_rlast),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_wnext  (d_wnext),
      .d_rvalid (d_rvalid),
      .d_last   (d_last),
      .rdata    (rdata),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic        got;
      logic        exp_d;
      logic [31:0] wrap_addr [4];
      int          exp_starve [8];

      wrap_addr  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      exp_starve = '{1, 2, 3, 0, 1, 2, 3, 0};

      rst = 1'b1; hold = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;

      // ---------------- reset state ----------------
      step(); step(); step();
      chk("rst_busy",    64'(busy), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_i_gnt",   64'(i_gnt), 64'd0);
      chk("rst_d_gnt",   64'(d_gnt), 64'd0);
      chk("rst_mem_addr",64'(mem_addr), 64'd0);
      chk("rst_starve",  64'(dut.r_starve), 64'd0);
      rst = 1'b0;

      // ---------------- I read burst, ack every cycle ----------------
      i_req = 1'b1; i_addr = 32'h1000; mem_ack = 1'b1; mem_rdata = 32'hA000;
      #1;
      chk("idle_ack_ignored_rvalid", 64'(i_rvalid), 64'd0);
      chk("idle_ack_ignored_rdata",  64'(rdata), 64'd0);
      chk("idle_busy",               64'(busy), 64'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         mem_rdata = 32'hA000 + 32'(k);
         if (k == 0) i_req = 1'b0;
         #1;
         chk("i1_gnt",    64'(i_gnt), (k == 0) ? 64'd1 : 64'd0);
         chk("i1_addr",   64'(mem_addr), 64'h1000 + 64'(4 * k));
         chk("i1_rvalid", 64'(i_rvalid), 64'd1);
         chk("i1_rdata",  64'(rdata), 64'hA000 + 64'(k));
         chk("i1_rlast",  64'(i_rlast), (k == 3) ? 64'd1 : 64'd0);
         chk("i1_we",     64'(mem_we), 64'd0);
         chk("i1_d_rvalid", 64'(d_rvalid), 64'd0);
      end
      step();
      chk("i1_done_busy",   64'(busy), 64'd0);
      chk("i1_done_rvalid", 64'(i_rvalid), 64'd0);

      // ---------------- D write-back, ack every 2nd cycle ----------------
      mem_ack = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h100;
      step();
      chk("d2_gnt", 64'(d_gnt), 64'd1);
      d_req = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin
            step();
            if (c % 2 == 0) d_wdata = d_wdata + 32'd1;
         end
         mem_ack = (c % 2 == 1);
         #1;
         chk("d2_busy",  64'(busy), 64'd1);
         chk("d2_we",    64'(mem_we), 64'd1);
         chk("d2_addr",  64'(mem_addr), 64'h2000 + 64'(4 * (c / 2)));
         chk("d2_wdata", 64'(mem_wdata), 64'h100 + 64'(c / 2));
         chk("d2_wnext", 64'(d_wnext), 64'(c % 2));
         chk("d2_last",  64'(d_last), (c == 7) ? 64'd1 : 64'd0);
         chk("d2_rvalid",64'(d_rvalid), 64'd0);
      end
      step();
      mem_ack = 1'b0;
      #1;
      chk("d2_done_busy", 64'(busy), 64'd0);
      chk("d2_starve_unchanged", 64'(dut.r_starve), 64'd0);

      // ---------------- starvation: both requesters held high ----------------
      d_we = 1'b0; d_addr = 32'h2000; i_addr = 32'h1000;
      mem_ack = 1'b1; mem_rdata = 32'h5A5A;
      i_req = 1'b1; d_req = 1'b1;
      for (int g = 0; g < 8; g++) begin
         got = 1'b0;
         for (int t = 0; t < 12 && !got; t++) begin
            step();
            if (i_gnt || d_gnt) got = 1'b1;
         end
         chk("st_gnt_seen", 64'(got), 64'd1);
         exp_d = !(g == 3 || g == 7);
         chk("st_order_d", 64'(d_gnt), 64'(exp_d));
         chk("st_order_i", 64'(i_gnt), 64'(!exp_d));
         chk("st_cnt",     64'(dut.r_starve), 64'(exp_starve[g]));
         if (exp_d) chk("st_d_rvalid", 64'(d_rvalid), 64'd1);
         else       chk("st_i_rvalid", 64'(i_rvalid), 64'd1);
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (4) step();
      chk("st_done_busy", 64'(busy), 64'd0);

      // ---------------- hold asserted mid D burst, I pending ----------------
      mem_ack = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
      step();
      chk("h_d_gnt", 64'(d_gnt), 64'd1);
      d_req = 1'b0; i_req = 1'b1; i_addr = 32'h4000;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         if (k == 1) hold = 1'b1;
         mem_ack = 1'b1;
         #1;
         chk("h_busy",   64'(busy), 64'd1);
         chk("h_rvalid", 64'(d_rvalid), 64'd1);
         chk("h_addr",   64'(mem_addr), 64'h3000 + 64'(4 * k));
         chk("h_last",   64'(d_last), (k == 3) ? 64'd1 : 64'd0);
         chk("h_no_i_gnt", 64'(i_gnt), 64'd0);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         chk("h_idle_busy",   64'(busy), 64'd0);
         chk("h_idle_i_gnt",  64'(i_gnt), 64'd0);
         chk("h_idle_rvalid", 64'(i_rvalid), 64'd0);
      end
      step();
      hold = 1'b0;
      #1;
      chk("h_fall_no_gnt_yet", 64'(i_gnt), 64'd0);
      step();
      chk("h_i_gnt_after_fall", 64'(i_gnt), 64'd1);
      chk("h_i_addr",           64'(mem_addr), 64'h4000);
      i_req = 1'b0;

      // ---------------- async reset mid I burst ----------------
      step();
      step();
      chk("r_beat2_addr", 64'(mem_addr), 64'h4008);
      rst = 1'b1;
      #1;
      chk("r_mem_req", 64'(mem_req), 64'd0);
      chk("r_busy",    64'(busy), 64'd0);
      chk("r_rvalid",  64'(i_rvalid), 64'd0);
      chk("r_addr",    64'(mem_addr), 64'd0);
      step();
      rst = 1'b0; i_req = 1'b1; i_addr = 32'h5000;
      step();
      chk("r_restart_gnt",  64'(i_gnt), 64'd1);
      chk("r_restart_addr", 64'(mem_addr), 64'h5000);
      i_req = 1'b0;
      repeat (4) step();
      chk("r_restart_done", 64'(busy), 64'd0);

      // ---------------- address wrap at top of memory ----------------
      i_req = 1'b1; i_addr = 32'hFFFF_FFF8;
      step();
      chk("w_gnt", 64'(i_gnt), 64'd1);
      i_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         #1;
         chk("w_addr",  64'(mem_addr), 64'(wrap_addr[k]));
         chk("w_rlast", 64'(i_rlast), (k == 3) ? 64'd1 : 64'd0);
      end
      step();
      chk("w_done_busy", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
